// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle computer's I/O input conditioning.
package sc_io_pkg;

  localparam int unsigned IO_W              = 32;
  localparam int unsigned DB_CYCLES_DEFAULT = 50000;
  localparam int unsigned KEY_LEVEL_LSB     = 0;

  // Sticky press flags sit directly above the key levels in in_port1.
  function automatic int unsigned key_sticky_lsb(input int unsigned key_w);
    return KEY_LEVEL_LSB + key_w;
  endfunction

endpackage

// File: rtl/sc_debounce_bit.sv
// One-bit two-flop synchroniser followed by a stability-counter debouncer.
module sc_debounce_bit
  import sc_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic clock,
  input  logic clrn,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_s1     <= RST_VAL;
      r_s2     <= RST_VAL;
      r_stable <= RST_VAL;
      r_cnt    <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_stable;

endmodule

// File: rtl/sc_io_input_cond.sv
// Switch/key conditioning feeding the memory-mapped input ports.
// Optional sticky key-press flags are built when SC_IO_KEY_STICKY_EN is defined.
module sc_io_input_cond
  import sc_io_pkg::*;
#(
  parameter int unsigned SW_W      = 10,
  parameter int unsigned KEY_W     = 4,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [KEY_W-1:0] key_n_raw,
  input  logic             ack,
  input  logic [KEY_W-1:0] ack_mask,
  output logic [IO_W-1:0]  in_port0,
  output logic [IO_W-1:0]  in_port1
);

  logic [SW_W-1:0]  w_sw_db;
  logic [KEY_W-1:0] w_key_db;
  logic [SW_W-1:0]  r_sw_lvl;
  logic [KEY_W-1:0] r_key_lvl;
  logic [IO_W-1:0]  w_port1;

  for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
    sc_debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db (
      .clock (clock),
      .clrn  (clrn),
      .din   (sw_raw[gi]),
      .dout  (w_sw_db[gi])
    );
  end

  // Keys are inverted before synchronising so everything downstream is 1 = pressed.
  for (genvar gk = 0; gk < KEY_W; gk++) begin : g_key
    sc_debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db (
      .clock (clock),
      .clrn  (clrn),
      .din   (~key_n_raw[gk]),
      .dout  (w_key_db[gk])
    );
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_sw_lvl  <= '0;
      r_key_lvl <= '0;
    end else begin
      r_sw_lvl  <= w_sw_db;
      r_key_lvl <= w_key_db;
    end
  end

`ifdef SC_IO_KEY_STICKY_EN
  localparam int unsigned KEY_STICKY_LSB = key_sticky_lsb(KEY_W);

  logic [KEY_W-1:0] r_sticky;
  logic [KEY_W-1:0] w_press;
  logic [KEY_W-1:0] w_clr;

  // r_key_lvl is last cycle's stable level, so the flag and the level appear together.
  assign w_press = w_key_db & ~r_key_lvl;
  assign w_clr   = {KEY_W{ack}} & ack_mask;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~w_clr) | w_press;
    end
  end

  always_comb begin
    w_port1 = '0;
    w_port1[KEY_LEVEL_LSB +: KEY_W]  = r_key_lvl;
    w_port1[KEY_STICKY_LSB +: KEY_W] = r_sticky;
  end
`else
  logic w_unused_ack;
  assign w_unused_ack = ^{ack, ack_mask};

  always_comb begin
    w_port1 = '0;
    w_port1[KEY_LEVEL_LSB +: KEY_W] = r_key_lvl;
  end
`endif

  assign in_port0 = IO_W'(r_sw_lvl);
  assign in_port1 = w_port1;

endmodule

// File: tb/tb_sc_io_input_cond.sv
// Directed and randomized bench for sc_io_input_cond against a rule-level model.
module tb_sc_io_input_cond;

  localparam int SW_W  = 10;
  localparam int KEY_W = 4;
  localparam int DB    = 4;
`ifdef SC_IO_KEY_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             clrn;
  logic [SW_W-1:0]  sw_raw;
  logic [KEY_W-1:0] key_n_raw;
  logic             ack;
  logic [KEY_W-1:0] ack_mask;
  logic [31:0]      in_port0;
  logic [31:0]      in_port1;

  int n_cmp = 0;
  int n_bad = 0;

  sc_io_input_cond #(.SW_W(SW_W), .KEY_W(KEY_W), .DB_CYCLES(DB)) dut (
    .clock     (clock),
    .clrn      (clrn),
    .sw_raw    (sw_raw),
    .key_n_raw (key_n_raw),
    .ack       (ack),
    .ack_mask  (ack_mask),
    .in_port0  (in_port0),
    .in_port1  (in_port1)
  );

  always #5 clock = ~clock;

  // Reference model: each synchronised bit must disagree with its accepted level
  // on DB consecutive edges before the new level is accepted.
  logic [SW_W-1:0]  m_sw_s1, m_sw_s2, m_sw_st, m_sw_out;
  logic [KEY_W-1:0] m_k_s1, m_k_s2, m_k_st, m_k_out, m_sticky;
  int               sw_run [SW_W];
  int               k_run  [KEY_W];

  task automatic model_reset();
    m_sw_s1 = '0; m_sw_s2 = '0; m_sw_st = '0; m_sw_out = '0;
    m_k_s1  = '0; m_k_s2  = '0; m_k_st  = '0; m_k_out  = '0; m_sticky = '0;
    for (int i = 0; i < SW_W; i++) sw_run[i] = 0;
    for (int i = 0; i < KEY_W; i++) k_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [KEY_W-1:0] clr;
    if (!clrn) return;
    clr      = ack ? ack_mask : '0;
    m_sticky = (m_sticky & ~clr) | (m_k_st & ~m_k_out);
    m_sw_out = m_sw_st;
    m_k_out  = m_k_st;
    for (int i = 0; i < SW_W; i++) begin
      if (m_sw_s2[i] != m_sw_st[i]) begin
        sw_run[i]++;
        if (sw_run[i] == DB) begin
          m_sw_st[i] = m_sw_s2[i];
          sw_run[i]  = 0;
        end
      end else sw_run[i] = 0;
    end
    for (int i = 0; i < KEY_W; i++) begin
      if (m_k_s2[i] != m_k_st[i]) begin
        k_run[i]++;
        if (k_run[i] == DB) begin
          m_k_st[i] = m_k_s2[i];
          k_run[i]  = 0;
        end
      end else k_run[i] = 0;
    end
    m_sw_s2 = m_sw_s1;
    m_sw_s1 = sw_raw;
    m_k_s2  = m_k_s1;
    m_k_s1  = ~key_n_raw;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e1;
    e1 = 32'(m_k_out);
    if (STICKY) e1 = e1 | (32'(m_sticky) << KEY_W);
    check({tag, "_p0"}, in_port0, 32'(m_sw_out));
    check({tag, "_p1"}, in_port1, e1);
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  int hold;

  initial begin
    clrn = 1'b1; sw_raw = '1; key_n_raw = '1; ack = 1'b0; ack_mask = '0;
    model_reset();
    #2;
    clrn = 1'b0;
    model_reset();

    // Reset with all switches on, keys released; switches appear at edge 6 after release.
    ticks("rst_hold", 3);
    check("rst_p0_zero", in_port0, 32'h0);
    check("rst_p1_zero", in_port1, 32'h0);
    clrn = 1'b1;
    ticks("rst_rel", 6);
    check("rst_edge5_p0", in_port0, 32'h0);
    tick("rst_rel6");
    check("rst_edge6_p0", in_port0, 32'h3FF);

    // Switch 0 glitch shorter than the debounce window is rejected.
    sw_raw = 10'h3FE;
    ticks("sw_settle", 8);
    check("sw_settled", in_port0, 32'h3FE);
    sw_raw = 10'h3FF;
    ticks("sw_glitch", 3);
    sw_raw = 10'h3FE;
    for (int i = 0; i < 6; i++) begin
      tick("sw_glitch_after");
      check("sw_glitch_bit0", {31'b0, in_port0[0]}, 32'h0);
    end

    // Key 2 press and release.
    key_n_raw = 4'hB;
    ticks("k2_press", 6);
    check("k2_edge5", in_port1, 32'h0);
    tick("k2_press6");
    check("k2_edge6", in_port1, STICKY ? 32'h44 : 32'h04);
    key_n_raw = 4'hF;
    ticks("k2_rel", 6);
    check("k2_rel_edge5", in_port1, STICKY ? 32'h44 : 32'h04);
    tick("k2_rel6");
    check("k2_rel_edge6", in_port1, STICKY ? 32'h40 : 32'h00);

    // Ack with a non-matching mask keeps the flag; matching mask clears it.
    ack = 1'b1; ack_mask = 4'h1;
    tick("ack_m1");
    ack = 1'b0; ack_mask = '0;
    check("ack_m1_keeps", {31'b0, in_port1[6]}, STICKY ? 32'h1 : 32'h0);
    ack = 1'b1; ack_mask = 4'h4;
    tick("ack_m4");
    ack = 1'b0; ack_mask = '0;
    check("ack_m4_clears", {31'b0, in_port1[6]}, 32'h0);

    // Press of key 1 completes on the same edge that an ack for key 1 is sampled.
    key_n_raw = 4'hD;
    ticks("k1_press", 6);
    ack = 1'b1; ack_mask = 4'h2;
    tick("k1_ack_same");
    ack = 1'b0; ack_mask = '0;
    check("set_wins_bit5", {31'b0, in_port1[5]}, STICKY ? 32'h1 : 32'h0);
    check("set_wins_word", in_port1, STICKY ? 32'h22 : 32'h02);
    key_n_raw = 4'hF;
    ticks("k1_rel", 8);
    ack = 1'b1; ack_mask = 4'hF;
    tick("ack_all");
    ack = 1'b0; ack_mask = '0;
    check("ack_all_word", in_port1, 32'h0);

    // Reset asserted while key 3's counter sits at 2.
    key_n_raw = 4'h7;
    ticks("k3_mid", 4);
    clrn = 1'b0;
    model_reset();
    #1;
    check("midrst_p0", in_port0, 32'h0);
    check("midrst_p1", in_port1, 32'h0);
    key_n_raw = 4'hF;
    ticks("midrst_hold", 2);
    clrn = 1'b1;
    ticks("midrst_rel", 10);
    check("midrst_no_sticky", in_port1, 32'h0);

    // Randomized levels, hold times and acks.
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        sw_raw    = SW_W'($urandom);
        key_n_raw = KEY_W'($urandom);
        hold      = int'($urandom_range(1, 8));
      end
      hold--;
      ack      = ($urandom_range(0, 7) == 0);
      ack_mask = KEY_W'($urandom);
      tick("rand");
    end
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
